// File: rtl/usr_shift_ctrl_if.sv
// Command channel between a word-level producer and the shift sequencer.
// The producer holds cmd_valid and the payload until it sees cmd_ready at a clock edge.
interface usr_shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_data;
  logic             cmd_dir;
  logic             cmd_rot;
  logic             cmd_fill;

  modport master (
    output cmd_valid,
    output cmd_data,
    output cmd_dir,
    output cmd_rot,
    output cmd_fill,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_data,
    input  cmd_dir,
    input  cmd_rot,
    input  cmd_fill,
    output cmd_ready
  );
endinterface

// File: rtl/usr_shift_ctrl.sv
// Sequencer for the universal shift register: parallel-loads one commanded word,
// streams it out serially for WIDTH cycles, then reports the final contents and a self-check.
module usr_shift_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  usr_shift_ctrl_if.slave  cmd_bus,
  output logic [1:0]       usr_select,
  output logic [WIDTH-1:0] usr_p_din,
  output logic             usr_s_left_din,
  output logic             usr_s_right_din,
  input  logic [WIDTH-1:0] usr_p_dout,
  input  logic             usr_s_left_dout,
  input  logic             usr_s_right_dout,
  output logic             bit_valid,
  output logic             bit_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             match
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] data_q;
  logic             dir_q;
  logic             rot_q;
  logic             fill_q;
  logic [CW-1:0]    count;
  logic             accept;
  logic             exit_bit;
  logic             enter_bit;
  logic [WIDTH-1:0] expected;

  assign accept    = cmd_bus.cmd_valid && cmd_bus.cmd_ready;
  assign exit_bit  = dir_q ? usr_s_left_dout : usr_s_right_dout;
  assign enter_bit = rot_q ? exit_bit : fill_q;
  // A rotation returns the loaded word; a fill leaves every bit equal to the fill value.
  assign expected  = rot_q ? data_q : {WIDTH{fill_q}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      dir_q  <= 1'b0;
      rot_q  <= 1'b0;
      fill_q <= 1'b0;
      count  <= '0;
      result <= '0;
      match  <= 1'b0;
    end else begin
      if (accept) begin
        data_q <= cmd_bus.cmd_data;
        dir_q  <= cmd_bus.cmd_dir;
        rot_q  <= cmd_bus.cmd_rot;
        fill_q <= cmd_bus.cmd_fill;
      end
      case (state)
        LOAD:  count <= '0;
        SHIFT: count <= count + CW'(1);
        // The last shift lands at the edge entering DONE, so the register is final here.
        DONE: begin
          result <= usr_p_dout;
          match  <= (usr_p_dout == expected);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = LOAD;
      LOAD:    state_next = SHIFT;
      SHIFT:   if (count == CW'(WIDTH - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    cmd_bus.cmd_ready = (state == IDLE) && !rst;
    usr_select        = 2'b00;
    usr_p_din         = '0;
    usr_s_left_din    = 1'b0;
    usr_s_right_din   = 1'b0;
    bit_valid         = 1'b0;
    bit_data          = 1'b0;
    busy              = (state != IDLE);
    done              = 1'b0;
    case (state)
      LOAD: begin
        usr_select = 2'b11;
        usr_p_din  = data_q;
      end
      SHIFT: begin
        usr_select = dir_q ? 2'b10 : 2'b01;
        bit_valid  = 1'b1;
        bit_data   = exit_bit;
        if (dir_q) begin
          usr_s_right_din = enter_bit;
        end else begin
          usr_s_left_din = enter_bit;
        end
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_usr_shift_ctrl.sv
// Scoreboard bench for usr_shift_ctrl driving a behavioural universal register model
// whose parallel output can have its LSB forced to 0.
module tb_usr_shift_ctrl;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       usr_select;
  logic [WIDTH-1:0] usr_p_din;
  logic             usr_s_left_din;
  logic             usr_s_right_din;
  logic [WIDTH-1:0] usr_p_dout;
  logic             usr_s_left_dout;
  logic             usr_s_right_dout;
  logic             bit_valid;
  logic             bit_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             match;

  logic [WIDTH-1:0] reg_q = '0;
  logic             stuck_lsb = 1'b0;
  int               cycle = 0;
  int               total = 0;
  int               bad = 0;

  typedef struct {
    logic [WIDTH-1:0] bits;
    logic [1:0]       sel;
    logic [WIDTH-1:0] res;
    logic             mat;
    int               done_cycle;
  } exp_t;

  exp_t exp_q[$];

  usr_shift_ctrl_if #(.WIDTH(WIDTH)) cmd_bus ();

  usr_shift_ctrl #(.WIDTH(WIDTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_bus          (cmd_bus),
    .usr_select       (usr_select),
    .usr_p_din        (usr_p_din),
    .usr_s_left_din   (usr_s_left_din),
    .usr_s_right_din  (usr_s_right_din),
    .usr_p_dout       (usr_p_dout),
    .usr_s_left_dout  (usr_s_left_dout),
    .usr_s_right_dout (usr_s_right_dout),
    .bit_valid        (bit_valid),
    .bit_data         (bit_data),
    .busy             (busy),
    .done             (done),
    .result           (result),
    .match            (match)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // The stuck fault affects only the parallel read-back; the serial taps see the true bits.
  always @(posedge clk) begin
    case (usr_select)
      2'b01:   reg_q <= {usr_s_left_din, reg_q[WIDTH-1:1]};
      2'b10:   reg_q <= {reg_q[WIDTH-2:0], usr_s_right_din};
      2'b11:   reg_q <= usr_p_din;
      default: reg_q <= reg_q;
    endcase
  end

  assign usr_p_dout       = stuck_lsb ? {reg_q[WIDTH-1:1], 1'b0} : reg_q;
  assign usr_s_left_dout  = reg_q[WIDTH-1];
  assign usr_s_right_dout = reg_q[0];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, required);
    end
  endtask

  task automatic report_fail(input string name);
    total++;
    bad++;
    $display("[TB] FAIL %s", name);
  endtask

  // exp_bits lists the exiting bits left to right in the order they should appear.
  task automatic apply_stimulus(input logic [WIDTH-1:0] data, input logic dir, input logic rot,
                                input logic fill, input logic [WIDTH-1:0] exp_bits,
                                input logic [WIDTH-1:0] exp_res, input logic exp_mat,
                                input bit keep, output int waited, output int accept_cycle);
    exp_t e;
    waited = 0;
    accept_cycle = -1;
    @(negedge clk);
    cmd_bus.cmd_data  = data;
    cmd_bus.cmd_dir   = dir;
    cmd_bus.cmd_rot   = rot;
    cmd_bus.cmd_fill  = fill;
    cmd_bus.cmd_valid = 1'b1;
    while (!cmd_bus.cmd_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!cmd_bus.cmd_ready) begin
      report_fail("accept_timeout");
      cmd_bus.cmd_valid = 1'b0;
      return;
    end
    e.bits       = exp_bits;
    e.sel        = dir ? 2'b10 : 2'b01;
    e.res        = exp_res;
    e.mat        = exp_mat;
    e.done_cycle = cycle + WIDTH + 2;
    exp_q.push_back(e);
    accept_cycle = cycle + 1;
    @(posedge clk);
    if (!keep) begin
      #1;
      cmd_bus.cmd_valid = 1'b0;
      cmd_bus.cmd_data  = ~data;
      cmd_bus.cmd_dir   = ~dir;
      cmd_bus.cmd_rot   = ~rot;
      cmd_bus.cmd_fill  = ~fill;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (exp_q.size() != 0) report_fail("drain_timeout");
    @(negedge clk);
  endtask

  initial begin : monitor
    int   idx = 0;
    bit   pending = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        idx = 0;
        pending = 1'b0;
      end else begin
        if (pending) begin
          check_output("result", result, exp_q[0].res);
          check_output("match", match, exp_q[0].mat);
          void'(exp_q.pop_front());
          pending = 1'b0;
          idx = 0;
        end
        if (bit_valid) begin
          if (exp_q.size() == 0) begin
            report_fail("unexpected_bit");
          end else if (idx >= WIDTH) begin
            report_fail("extra_bit");
          end else begin
            check_output("bit_data", bit_data, exp_q[0].bits[WIDTH-1-idx]);
            check_output("shift_select", usr_select, exp_q[0].sel);
            idx++;
          end
        end
        if (done) begin
          if (exp_q.size() == 0) begin
            report_fail("unexpected_done");
          end else begin
            check_output("done_cycle", cycle, exp_q[0].done_cycle);
            check_output("bit_count", idx, WIDTH);
            check_output("done_select", usr_select, 2'b00);
            pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin : stimulus
    int w1, w2, a1, a2;
    cmd_bus.cmd_valid = 1'b0;
    cmd_bus.cmd_data  = '0;
    cmd_bus.cmd_dir   = 1'b0;
    cmd_bus.cmd_rot   = 1'b0;
    cmd_bus.cmd_fill  = 1'b0;
    #1;
    check_output("reset_ready", cmd_bus.cmd_ready, 1'b0);
    check_output("reset_busy", busy, 1'b0);
    check_output("reset_select", usr_select, 2'b00);
    check_output("reset_result", result, '0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_output("ready_after_reset", cmd_bus.cmd_ready, 1'b1);

    apply_stimulus(4'b1101, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b1101, 1'b1, 1'b0, w1, a1);
    drain();
    apply_stimulus(4'b1101, 1'b1, 1'b0, 1'b0, 4'b1101, 4'b0000, 1'b1, 1'b0, w1, a1);
    drain();
    apply_stimulus(4'b0010, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b1111, 1'b1, 1'b0, w1, a1);
    drain();

    apply_stimulus(4'b1001, 1'b1, 1'b1, 1'b0, 4'b1001, 4'b1001, 1'b1, 1'b1, w1, a1);
    apply_stimulus(4'b0110, 1'b0, 1'b0, 1'b0, 4'b0110, 4'b0000, 1'b1, 1'b0, w2, a2);
    check_output("b2b_accept_gap", a2 - a1, WIDTH + 3);
    check_output("b2b_ready_low_cycles", w2, WIDTH + 2);
    drain();

    // Abort during the second shift cycle; everything observable must clear at once.
    apply_stimulus(4'b1010, 1'b0, 1'b1, 1'b0, 4'b0101, 4'b1010, 1'b1, 1'b0, w1, a1);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("abort_busy", busy, 1'b0);
    check_output("abort_bit_valid", bit_valid, 1'b0);
    check_output("abort_done", done, 1'b0);
    check_output("abort_select", usr_select, 2'b00);
    check_output("abort_serial_in", {usr_s_left_din, usr_s_right_din}, 2'b00);
    check_output("abort_result", result, '0);
    check_output("abort_match", match, 1'b0);
    check_output("abort_ready", cmd_bus.cmd_ready, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    apply_stimulus(4'b0111, 1'b1, 1'b0, 1'b1, 4'b0111, 4'b1111, 1'b1, 1'b0, w1, a1);
    drain();

    stuck_lsb = 1'b1;
    apply_stimulus(4'b1111, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1110, 1'b0, 1'b0, w1, a1);
    drain();
    stuck_lsb = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usr_shift_ctrl.md
# usr_shift_ctrl

Sequencer for the team's universal shift register: accepts one word per command over a valid/ready handshake, parallel-loads it into the register, then shifts it out serially for WIDTH cycles in the commanded direction. It streams each exiting bit, and on completion reports the register's final contents and a self-check flag. It sits between a word-level producer and the universal register, and owns that register's select and serial-input lines.

## Interface
- WIDTH, 4, register width in bits (≥2); the internal shift counter is sized to count 0..WIDTH-1.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  controller can accept a command
- cmd_data  in  WIDTH  word to load
- cmd_dir  in  1  0 = shift right (LSB first), 1 = shift left (MSB first)
- cmd_rot  in  1  1 = rotate (exiting bit re-enters); 0 = fill with cmd_fill
- cmd_fill  in  1  fill bit when cmd_rot=0
- usr_select  out  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 parallel load
- usr_p_din  out  WIDTH  parallel load data
- usr_s_left_din  out  1  bit entering at MSB on shift right
- usr_s_right_din  out  1  bit entering at LSB on shift left
- usr_p_dout  in  WIDTH  register contents
- usr_s_left_dout  in  1  register MSB (exits on shift left)
- usr_s_right_dout  in  1  register LSB (exits on shift right)
- bit_valid  out  1  bit_data is valid this cycle
- bit_data  out  1  serial bit currently exiting the register
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- result  out  WIDTH  register contents captured at done; held until the next done
- match  out  1  result equals the expected value; held with result

## Operation
- Register contract: on select 01, q <= {usr_s_left_din, q[W-1:1]}. On 10, q <= {q[W-2:0], usr_s_right_din}. On 11, q <= usr_p_din. On 00, hold.
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE: cmd_ready=1, select=00. On cmd_valid&&cmd_ready, latch data, dir, rot and fill, then go to LOAD.
- LOAD (1 cycle): select=11, usr_p_din=latched data. Go to SHIFT and clear the counter.
- SHIFT (WIDTH cycles): select=01 if dir=0, else 10.
  - Exiting bit: usr_s_right_dout when dir=0, usr_s_left_dout when dir=1.
  - Entering bit = rot ? exiting bit : fill. It drives usr_s_left_din (dir=0) or usr_s_right_din (dir=1); the unused serial input is 0.
  - bit_valid=1; bit_data = exiting bit.
  - The counter increments each cycle. At count WIDTH-1, go to DONE.
- DONE (1 cycle): select=00, done=1.
  - result <= usr_p_dout.
  - Expected value = rot ? latched data : {WIDTH{fill}}; match <= (usr_p_dout == expected).
  - Go to IDLE.
- busy=1 in LOAD, SHIFT and DONE. cmd_ready=0 outside IDLE. A cmd_valid seen while busy is neither accepted nor lost; the producer holds it.
- Outputs are decoded from the state register (Moore). bit_data is a combinational pass-through of the register tap, gated by SHIFT.

## Timing
- Reset (async assert) values: state IDLE, select 00, usr_p_din 0, both serial inputs 0, bit_valid 0, bit_data 0, busy 0, done 0, result 0, match 0, counter 0. cmd_ready is 0 while rst is high and 1 after release.
- Accept edge = E0. LOAD is the cycle after E0. SHIFT occupies the cycles after E1..E(WIDTH). done is high in the cycle after E(WIDTH+1). IDLE follows E(WIDTH+2).
- Next accept is at E(WIDTH+3) at the earliest, giving a command period of WIDTH+3 cycles. Accept in DONE is not permitted.
- Bit order: dir=0 gives cmd_data[0], [1], … [W-1]. dir=1 gives cmd_data[W-1] … [0]. Exactly WIDTH bit_valid cycles per command, contiguous.
- Reset mid-command aborts immediately: no done, result/match are cleared, and the register is left in whatever state it holds (select 00).
- The cmd_* inputs are sampled only at the accept edge; later changes have no effect.

## Test plan
- WIDTH=4, data 1101, dir 0, rot 1 -> LOAD then select 01×4; bits 1,0,1,1; done at the 5th edge after accept; result 1101, match 1.
- data 1101, dir 1, rot 0, fill 0 -> select 10×4; bits 1,1,0,1; result 0000, match 1.
- data 0010, dir 0, rot 0, fill 1 -> bits 0,1,0,0; result 1111, match 1.
- cmd_valid held high continuously for two commands -> cmd_ready low from LOAD through DONE; second accept exactly 7 cycles after the first; no bit lost or duplicated.
- rst pulsed during the 2nd SHIFT cycle -> all outputs go to reset values asynchronously, no done; the next command after release completes normally.
- Register model with the LSB stuck at 0, data 1111, rot 1, dir 0 -> result 1110, match 0.
